procb_state_restore: RTL and testbench

- Controller on the access side of the per-thread process_bytes saved-state memory (SAVE_WIDTH x N_THREADS, registered read, 1-cycle read latency).
- Tracks which threads hold a valid saved record and turns single-cycle save requests into memory writes.
- Serves restore requests through a req/ready + valid/ack handshake, returning saved data or a miss indication.
- Forwards saves that race with an in-flight restore of the same thread, so the consumer always gets the newest record.

---
 rtl/procb_state_restore_pkg.sv | 26 ++
 rtl/procb_state_restore.sv | 144 ++++++++++++++
 tb/tb_procb_state_restore.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/procb_state_restore_pkg.sv
// Shared sizing defaults and FSM encoding for the process_bytes state-restore controller.
package procb_state_restore_pkg;

    localparam int N_THREADS_DEF    = 8;
    localparam int PROCB_SAVE_WIDTH = 64;

    // Index of the highest set bit (0 for an argument of 0 or 1).
    function automatic int msb(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if (((v >> i) & 1) != 0) begin
                r = i;
            end
        end
        return r;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_CAP  = 2'd2,
        ST_RESP = 2'd3
    } restore_state_t;

endpackage

// File: rtl/procb_state_restore.sv
// Access-side controller for the per-thread saved-state memory: records which
// threads hold a saved record, turns saves into memory writes, and serves one
// restore at a time, forwarding saves that race with the in-flight restore.
module procb_state_restore
    import procb_state_restore_pkg::*;
#(
    parameter int N_THREADS     = N_THREADS_DEF,
    parameter int N_THREADS_MSB = msb(N_THREADS - 1),
    parameter int SAVE_WIDTH    = PROCB_SAVE_WIDTH
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic                     save_en,
    input  logic [N_THREADS_MSB:0]   save_thread_num,
    input  logic [SAVE_WIDTH-1:0]    save_data,
    input  logic                     restore_req,
    input  logic [N_THREADS_MSB:0]   restore_thread_num,
    output logic                     restore_ready,
    output logic                     restore_valid,
    output logic                     restore_hit,
    output logic [SAVE_WIDTH-1:0]    restore_data,
    input  logic                     restore_ack,
    output logic                     mem_wr_en,
    output logic [N_THREADS_MSB:0]   mem_wr_thread_num,
    output logic [SAVE_WIDTH-1:0]    mem_din,
    output logic                     mem_rd_en,
    output logic [N_THREADS_MSB:0]   mem_rd_thread_num,
    input  logic [SAVE_WIDTH-1:0]    mem_dout
);

    restore_state_t           r_state;
    logic [N_THREADS-1:0]     r_flags;
    logic [N_THREADS_MSB:0]   r_cur_thread;
    logic                     r_valid;
    logic                     r_hit;
    logic [SAVE_WIDTH-1:0]    r_data;
    logic                     r_fwd;
    logic                     r_rd_en;
    logic [N_THREADS_MSB:0]   r_rd_thread;

    logic [N_THREADS-1:0]     w_flags_nxt;
    logic                     w_accept;
    logic                     w_acc_hit;
    logic                     w_fwd;
    logic                     w_ack;

    // Saves are never back-pressured: they go straight to the memory write port.
    assign mem_wr_en         = save_en & ~reset;
    assign mem_wr_thread_num = save_thread_num;
    assign mem_din           = save_data;

    assign restore_ready     = (r_state == ST_IDLE);
    assign restore_valid     = r_valid;
    assign restore_hit       = r_hit;
    assign restore_data      = r_data;
    assign mem_rd_en         = r_rd_en;
    assign mem_rd_thread_num = r_rd_thread;

    assign w_accept  = restore_req & (r_state == ST_IDLE);
    // A save landing in the accept cycle is written before the RD-cycle read, so it counts as a hit.
    assign w_acc_hit = r_flags[restore_thread_num]
                     | (save_en & (save_thread_num == restore_thread_num));
    assign w_fwd     = save_en & (save_thread_num == r_cur_thread);
    assign w_ack     = (r_state == ST_RESP) & restore_ack;

    // Next saved-flag vector: an acked restore consumes its record, but a save in the same cycle wins.
    always_comb begin
        w_flags_nxt = r_flags;
        if (w_ack) begin
            w_flags_nxt[r_cur_thread] = 1'b0;
        end
        if (save_en) begin
            w_flags_nxt[save_thread_num] = 1'b1;
        end
    end

    // Restore FSM with registered response and memory-read outputs.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_flags      <= '0;
            r_cur_thread <= '0;
            r_valid      <= 1'b0;
            r_hit        <= 1'b0;
            r_data       <= '0;
            r_fwd        <= 1'b0;
            r_rd_en      <= 1'b0;
            r_rd_thread  <= '0;
        end else begin
            r_flags <= w_flags_nxt;
            unique case (r_state)
                ST_IDLE: begin
                    r_rd_en <= 1'b0;
                    if (w_accept) begin
                        r_cur_thread <= restore_thread_num;
                        r_fwd        <= 1'b0;
                        if (w_acc_hit) begin
                            r_state     <= ST_RD;
                            r_rd_en     <= 1'b1;
                            r_rd_thread <= restore_thread_num;
                        end else begin
                            r_state <= ST_RESP;
                            r_valid <= 1'b1;
                            r_hit   <= 1'b0;
                            r_data  <= '0;
                        end
                    end
                end
                ST_RD: begin
                    // The read in flight returns the pre-save record, so a racing save must be kept aside.
                    r_rd_en <= 1'b0;
                    r_state <= ST_CAP;
                    if (w_fwd) begin
                        r_data <= save_data;
                        r_fwd  <= 1'b1;
                    end
                end
                ST_CAP: begin
                    r_state <= ST_RESP;
                    r_valid <= 1'b1;
                    r_hit   <= 1'b1;
                    if (w_fwd) begin
                        r_data <= save_data;
                    end else if (!r_fwd) begin
                        r_data <= mem_dout;
                    end
                end
                ST_RESP: begin
                    if (restore_ack) begin
                        r_state <= ST_IDLE;
                        r_valid <= 1'b0;
                        r_hit   <= 1'b0;
                        r_data  <= '0;
                        r_fwd   <= 1'b0;
                    end else if (w_fwd) begin
                        r_hit  <= 1'b1;
                        r_data <= save_data;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_procb_state_restore.sv
// Bench for procb_state_restore with a behavioural saved-state memory
// (registered read, one-cycle latency).
module tb_procb_state_restore;

    localparam int NT = 8;
    localparam int TW = 3;
    localparam int W  = 64;

    logic          CLK;
    logic          reset;
    logic          save_en;
    logic [TW-1:0] save_thread_num;
    logic [W-1:0]  save_data;
    logic          restore_req;
    logic [TW-1:0] restore_thread_num;
    logic          restore_ready;
    logic          restore_valid;
    logic          restore_hit;
    logic [W-1:0]  restore_data;
    logic          restore_ack;
    logic          mem_wr_en;
    logic [TW-1:0] mem_wr_thread_num;
    logic [W-1:0]  mem_din;
    logic          mem_rd_en;
    logic [TW-1:0] mem_rd_thread_num;
    logic [W-1:0]  mem_dout;

    procb_state_restore #(
        .N_THREADS     (NT),
        .N_THREADS_MSB (TW - 1),
        .SAVE_WIDTH    (W)
    ) dut (
        .CLK                (CLK),
        .reset              (reset),
        .save_en            (save_en),
        .save_thread_num    (save_thread_num),
        .save_data          (save_data),
        .restore_req        (restore_req),
        .restore_thread_num (restore_thread_num),
        .restore_ready      (restore_ready),
        .restore_valid      (restore_valid),
        .restore_hit        (restore_hit),
        .restore_data       (restore_data),
        .restore_ack        (restore_ack),
        .mem_wr_en          (mem_wr_en),
        .mem_wr_thread_num  (mem_wr_thread_num),
        .mem_din            (mem_din),
        .mem_rd_en          (mem_rd_en),
        .mem_rd_thread_num  (mem_rd_thread_num),
        .mem_dout           (mem_dout)
    );

    // Saved-state memory: write port and registered read (read-before-write on collision).
    logic [W-1:0] mem [NT];
    always @(posedge CLK) begin
        if (mem_wr_en) mem[mem_wr_thread_num] <= mem_din;
        if (mem_rd_en) mem_dout <= mem[mem_rd_thread_num];
    end

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic          rst;
        logic          sen;
        logic [TW-1:0] sthr;
        logic [W-1:0]  sdat;
        logic          req;
        logic [TW-1:0] rthr;
        logic          ack;
        logic          e_rdy;
        logic          e_vld;
        logic          e_hit;
        logic [W-1:0]  e_dat;
        logic          e_rd;
        logic [TW-1:0] e_rdthr;
        logic          hd;
    } vec_t;

    function automatic vec_t v(
        input logic rst, input logic sen, input int sthr, input logic [W-1:0] sdat,
        input logic req, input int rthr, input logic ack,
        input logic e_rdy, input logic e_vld, input logic e_hit, input logic [W-1:0] e_dat,
        input logic e_rd, input int e_rdthr, input logic hd);
        vec_t r;
        r.rst = rst; r.sen = sen; r.sthr = TW'(sthr); r.sdat = sdat;
        r.req = req; r.rthr = TW'(rthr); r.ack = ack;
        r.e_rdy = e_rdy; r.e_vld = e_vld; r.e_hit = e_hit; r.e_dat = e_dat;
        r.e_rd = e_rd; r.e_rdthr = TW'(e_rdthr); r.hd = hd;
        return r;
    endfunction

    localparam logic [W-1:0] DA = 64'hA5A5_A5A5_A5A5_A5A5;
    localparam logic [W-1:0] DX = 64'h1111_2222_3333_4444;
    localparam logic [W-1:0] DY = 64'h5555_6666_7777_8888;
    localparam logic [W-1:0] DZ = 64'h0123_4567_89AB_CDEF;
    localparam logic [W-1:0] DW = 64'hFEED_FACE_CAFE_BEEF;
    localparam logic [W-1:0] DB = 64'hBBBB_1234_BBBB_5678;
    localparam logic [W-1:0] DC = 64'hCCCC_0000_CCCC_0000;
    localparam logic [W-1:0] DD = 64'hDDDD_9999_DDDD_9999;

    vec_t tbl[$];

    // Reference model state: which threads hold a record and its newest value,
    // plus the one outstanding restore and the cycles left until its response shows.
    bit           m_flag [NT];
    logic [W-1:0] m_val  [NT];
    bit           m_busy;
    logic [TW-1:0] m_thr;
    int           m_cnt;
    bit           m_rdhit;
    bit           m_hit;
    logic [W-1:0] m_data;

    initial begin
        reset = 1'b1; save_en = 1'b0; save_thread_num = '0; save_data = '0;
        restore_req = 1'b0; restore_thread_num = '0; restore_ack = 1'b0;

        //             rst sen th data req th ack | rdy vld hit data rd rdth hd
        tbl.push_back(v(0, 0, 0, 0,  1, 3, 0,  1, 0, 0, 0,  0, 0, 1)); // r0 restore 3 after reset
        tbl.push_back(v(0, 0, 0, 0,  0, 0, 0,  0, 1, 0, 0,  0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0,  0, 0, 1,  0, 1, 0, 0,  0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0,  0, 0, 0,  1, 0, 0, 0,  0, 0, 0));
        tbl.push_back(v(0, 1, 5, DA, 0, 0, 0,  1, 0, 0, 0,  0, 0, 0)); // r4 save 5
        tbl.push_back(v(0, 0, 0, 0,  1, 5, 0,  1, 0, 0, 0,  0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0,  1, 5, 0));
        tbl.push_back(v(0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0,  0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0,  0, 0, 1,  0, 1, 1, DA, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0,  1, 5, 0,  1, 0, 0, 0,  0, 0, 0)); // r9 restore 5 again
        tbl.push_back(v(0, 0, 0, 0,  0, 0, 1,  0, 1, 0, 0,  0, 0, 0));
        tbl.push_back(v(0, 1, 5, DX, 0, 0, 0,  1, 0, 0, 0,  0, 0, 0)); // r11 forward in RD
        tbl.push_back(v(0, 0, 0, 0,  1, 5, 0,  1, 0, 0, 0,  0, 0, 0));
        tbl.push_back(v(0, 1, 5, DY, 0, 0, 0,  0, 0, 0, 0,  1, 5, 0));
        tbl.push_back(v(0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0,  0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0,  0, 0, 1,  0, 1, 1, DY, 0, 0, 0));
        tbl.push_back(v(0, 1, 5, DX, 0, 0, 0,  1, 0, 0, 0,  0, 0, 0)); // r16 forward in CAP
        tbl.push_back(v(0, 0, 0, 0,  1, 5, 0,  1, 0, 0, 0,  0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0,  1, 5, 0));
        tbl.push_back(v(0, 1, 5, DY, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0,  0, 0, 1,  0, 1, 1, DY, 0, 0, 0));
        tbl.push_back(v(0, 1, 5, DX, 0, 0, 0,  1, 0, 0, 0,  0, 0, 0)); // r21 forward in RESP
        tbl.push_back(v(0, 0, 0, 0,  1, 5, 0,  1, 0, 0, 0,  0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0,  1, 5, 0));
        tbl.push_back(v(0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0,  0, 0, 0));
        tbl.push_back(v(0, 1, 5, DY, 0, 0, 0,  0, 1, 1, DX, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0,  0, 0, 1,  0, 1, 1, DY, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0,  1, 2, 0,  1, 0, 0, 0,  0, 0, 0)); // r27 miss then forward
        tbl.push_back(v(0, 1, 2, DZ, 0, 0, 0,  0, 1, 0, 0,  0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0,  0, 0, 0,  0, 1, 1, DZ, 0, 0, 0));
        tbl.push_back(v(0, 1, 7, DW, 0, 0, 0,  0, 1, 1, DZ, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0,  0, 0, 0,  0, 1, 1, DZ, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0,  0, 0, 1,  0, 1, 1, DZ, 0, 0, 0));
        tbl.push_back(v(0, 1, 4, DB, 0, 0, 0,  1, 0, 0, 0,  0, 0, 0)); // r33 save on ack cycle
        tbl.push_back(v(0, 0, 0, 0,  1, 4, 0,  1, 0, 0, 0,  0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0,  1, 4, 0));
        tbl.push_back(v(0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0,  0, 0, 0));
        tbl.push_back(v(0, 1, 4, DC, 0, 0, 1,  0, 1, 1, DB, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0,  1, 4, 0,  1, 0, 0, 0,  0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0,  1, 4, 0));
        tbl.push_back(v(0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0,  0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0,  0, 0, 1,  0, 1, 1, DC, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0,  1, 7, 0,  1, 0, 0, 0,  0, 0, 0)); // r42 other-thread save kept
        tbl.push_back(v(0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0,  1, 7, 0));
        tbl.push_back(v(0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0,  0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0,  0, 0, 1,  0, 1, 1, DW, 0, 0, 0));
        tbl.push_back(v(0, 1, 6, DD, 0, 0, 0,  1, 0, 0, 0,  0, 0, 0)); // r46 reset during CAP
        tbl.push_back(v(0, 1, 5, DA, 1, 5, 0,  1, 0, 0, 0,  0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0,  1, 5, 0));
        tbl.push_back(v(1, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0,  0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0,  1, 5, 0,  1, 0, 0, 0,  0, 0, 1));
        tbl.push_back(v(0, 0, 0, 0,  0, 0, 1,  0, 1, 0, 0,  0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0,  1, 6, 0,  1, 0, 0, 0,  0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0,  0, 0, 1,  0, 1, 0, 0,  0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0,  0, 0, 0,  1, 0, 0, 0,  0, 0, 0));

        // Reset for two edges, then check the reset values of the registered outputs.
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        chk("reset restore_valid", W'(restore_valid), '0);
        chk("reset restore_hit", W'(restore_hit), '0);
        chk("reset restore_data", restore_data, '0);
        chk("reset mem_rd_en", W'(mem_rd_en), '0);
        chk("reset mem_rd_thread_num", W'(mem_rd_thread_num), '0);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            reset              = tbl[i].rst;
            save_en            = tbl[i].sen;
            save_thread_num    = tbl[i].sthr;
            save_data          = tbl[i].sdat;
            restore_req        = tbl[i].req;
            restore_thread_num = tbl[i].rthr;
            restore_ack        = tbl[i].ack;
            #1;
            chk($sformatf("row%0d restore_ready", i), W'(restore_ready), W'(tbl[i].e_rdy));
            chk($sformatf("row%0d restore_valid", i), W'(restore_valid), W'(tbl[i].e_vld));
            chk($sformatf("row%0d mem_rd_en", i), W'(mem_rd_en), W'(tbl[i].e_rd));
            chk($sformatf("row%0d mem_wr_en", i), W'(mem_wr_en), W'(tbl[i].sen & ~tbl[i].rst));
            if (tbl[i].e_rd)
                chk($sformatf("row%0d mem_rd_thread_num", i), W'(mem_rd_thread_num), W'(tbl[i].e_rdthr));
            if (tbl[i].e_vld || tbl[i].hd) begin
                chk($sformatf("row%0d restore_hit", i), W'(restore_hit), W'(tbl[i].e_hit));
                chk($sformatf("row%0d restore_data", i), restore_data, tbl[i].e_dat);
            end
            @(posedge CLK); #1;
        end

        // Randomized traffic against the reference model; the table leaves no saved records behind.
        for (int t = 0; t < NT; t++) begin
            m_flag[t] = 0;
            m_val[t]  = '0;
        end
        m_busy = 0; m_thr = '0; m_cnt = 0; m_rdhit = 0; m_hit = 0; m_data = '0;

        for (int c = 0; c < 3000; c++) begin
            bit e_vld;
            bit e_rd;
            reset              = ($urandom_range(0, 63) == 0);
            save_en            = ($urandom_range(0, 99) < 35);
            save_thread_num    = TW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 2));
            save_data          = {$urandom, $urandom};
            restore_req        = ($urandom_range(0, 99) < 50);
            restore_thread_num = TW'($urandom_range(0, 3));
            restore_ack        = ($urandom_range(0, 99) < 40);
            #1;
            e_vld = m_busy && (m_cnt == 0);
            e_rd  = m_busy && m_rdhit && (m_cnt == 2);
            chk($sformatf("rand%0d restore_ready", c), W'(restore_ready), W'(!m_busy));
            chk($sformatf("rand%0d restore_valid", c), W'(restore_valid), W'(e_vld));
            chk($sformatf("rand%0d mem_rd_en", c), W'(mem_rd_en), W'(e_rd));
            chk($sformatf("rand%0d mem_wr_en", c), W'(mem_wr_en), W'(save_en & ~reset));
            if (e_rd)
                chk($sformatf("rand%0d mem_rd_thread_num", c), W'(mem_rd_thread_num), W'(m_thr));
            if (e_vld) begin
                chk($sformatf("rand%0d restore_hit", c), W'(restore_hit), W'(m_hit));
                chk($sformatf("rand%0d restore_data", c), restore_data, m_data);
            end

            // Advance the model by one clock edge using this cycle's inputs.
            if (reset) begin
                m_busy = 0;
                for (int t = 0; t < NT; t++) m_flag[t] = 0;
            end else begin
                if (m_busy) begin
                    if (m_cnt == 0 && restore_ack) begin
                        m_busy = 0;
                        m_flag[m_thr] = 0;
                    end else begin
                        if (save_en && save_thread_num == m_thr) begin
                            m_hit  = 1;
                            m_data = save_data;
                        end
                        if (m_cnt > 0) m_cnt--;
                    end
                end else if (restore_req) begin
                    m_busy = 1;
                    m_thr  = restore_thread_num;
                    if (save_en && save_thread_num == restore_thread_num) begin
                        m_hit = 1; m_data = save_data; m_cnt = 2; m_rdhit = 1;
                    end else if (m_flag[restore_thread_num]) begin
                        m_hit = 1; m_data = m_val[restore_thread_num]; m_cnt = 2; m_rdhit = 1;
                    end else begin
                        m_hit = 0; m_data = '0; m_cnt = 0; m_rdhit = 0;
                    end
                end
                if (save_en) begin
                    m_flag[save_thread_num] = 1;
                    m_val[save_thread_num]  = save_data;
                end
            end
            @(posedge CLK); #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
